// File: rtl/ex_mem_pipe.sv
// EX/MEM pipeline stage: two-entry skid buffer (head H, skid S) carrying the
// writeback and memory-operation fields of each instruction, with flush, a
// global freeze, and a combinational operand-forwarding lookup over both slots.
// ex_ready depends only on registered state, so MEM back-pressure never forms
// a combinational path into EX.
module ex_mem_pipe #(
    parameter int REG_LEN      = 32,
    parameter int REG_ADDR_LEN = 5,
    parameter int ADDR_LEN     = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rdy,
    input  logic                    flush,

    input  logic                    ex_valid,
    output logic                    ex_ready,
    input  logic [REG_LEN-1:0]      ex_rd_data,
    input  logic [REG_ADDR_LEN-1:0] ex_rd_addr,
    input  logic                    ex_rd_enable,
    input  logic [1:0]              ex_mem_type,
    input  logic [2:0]              ex_mem_width,
    input  logic [ADDR_LEN-1:0]     ex_mem_addr,
    input  logic [REG_LEN-1:0]      ex_store_data,

    output logic                    mem_valid,
    input  logic                    mem_ready,
    output logic [REG_LEN-1:0]      mem_rd_data,
    output logic [REG_ADDR_LEN-1:0] mem_rd_addr,
    output logic                    mem_rd_enable,
    output logic [1:0]              mem_mem_type,
    output logic [2:0]              mem_mem_width,
    output logic [ADDR_LEN-1:0]     mem_mem_addr,
    output logic [REG_LEN-1:0]      mem_store_data,

    input  logic [REG_ADDR_LEN-1:0] fwd_query_addr,
    output logic                    fwd_hit,
    output logic [REG_LEN-1:0]      fwd_data,
    output logic                    fwd_is_load
);

    localparam logic [1:0] MEM_LOAD = 2'b01;

    typedef struct packed {
        logic [REG_LEN-1:0]      rd_data;
        logic [REG_ADDR_LEN-1:0] rd_addr;
        logic                    rd_enable;
        logic [1:0]              mem_type;
        logic [2:0]              mem_width;
        logic [ADDR_LEN-1:0]     mem_addr;
        logic [REG_LEN-1:0]      store_data;
    } entry_t;

    logic   h_valid_q, h_valid_d;
    logic   s_valid_q, s_valid_d;
    entry_t h_q, h_d;
    entry_t s_q, s_d;
    entry_t ex_entry;

    logic   push;
    logic   pop;
    logic   h_match;
    logic   s_match;

    assign ex_entry = '{
        rd_data:    ex_rd_data,
        rd_addr:    ex_rd_addr,
        rd_enable:  ex_rd_enable,
        mem_type:   ex_mem_type,
        mem_width:  ex_mem_width,
        mem_addr:   ex_mem_addr,
        store_data: ex_store_data
    };

    assign ex_ready = !rst && rdy && !s_valid_q;
    assign push     = ex_valid && ex_ready;
    assign pop      = h_valid_q && mem_ready && rdy;

    assign mem_valid      = h_valid_q;
    assign mem_rd_enable  = h_valid_q && h_q.rd_enable;
    assign mem_rd_data    = h_q.rd_data;
    assign mem_rd_addr    = h_q.rd_addr;
    assign mem_mem_type   = h_q.mem_type;
    assign mem_mem_width  = h_q.mem_width;
    assign mem_mem_addr   = h_q.mem_addr;
    assign mem_store_data = h_q.store_data;

    // Next-state of both slots: flush beats freeze beats the push/pop update.
    always_comb begin
        h_valid_d = h_valid_q;
        s_valid_d = s_valid_q;
        h_d       = h_q;
        s_d       = s_q;
        if (flush) begin
            // Fields are left as-is; only the valid bits matter after a flush.
            h_valid_d = 1'b0;
            s_valid_d = 1'b0;
        end else if (rdy) begin
            unique case ({push, pop})
                2'b01: begin
                    if (s_valid_q) begin
                        h_d       = s_q;
                        s_valid_d = 1'b0;
                    end else begin
                        h_valid_d = 1'b0;
                    end
                end
                2'b10: begin
                    if (!h_valid_q) begin
                        h_d       = ex_entry;
                        h_valid_d = 1'b1;
                    end else begin
                        s_d       = ex_entry;
                        s_valid_d = 1'b1;
                    end
                end
                2'b11: begin
                    // S is empty whenever a push is accepted, so the new entry
                    // goes straight into the head behind the departing one.
                    h_d       = ex_entry;
                    h_valid_d = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Slot registers with synchronous reset clearing valid bits and fields.
    always_ff @(posedge clk) begin
        if (rst) begin
            h_valid_q <= 1'b0;
            s_valid_q <= 1'b0;
            h_q       <= '0;
            s_q       <= '0;
        end else begin
            h_valid_q <= h_valid_d;
            s_valid_q <= s_valid_d;
            h_q       <= h_d;
            s_q       <= s_d;
        end
    end

    assign h_match = h_valid_q && h_q.rd_enable && (h_q.rd_addr == fwd_query_addr)
                     && (fwd_query_addr != '0);
    assign s_match = s_valid_q && s_q.rd_enable && (s_q.rd_addr == fwd_query_addr)
                     && (fwd_query_addr != '0);

    // Forwarding lookup; S is the younger entry so it wins over H.
    always_comb begin
        fwd_hit     = 1'b0;
        fwd_data    = '0;
        fwd_is_load = 1'b0;
        if (s_match) begin
            fwd_hit     = 1'b1;
            fwd_data    = s_q.rd_data;
            fwd_is_load = (s_q.mem_type == MEM_LOAD);
        end else if (h_match) begin
            fwd_hit     = 1'b1;
            fwd_data    = h_q.rd_data;
            fwd_is_load = (h_q.mem_type == MEM_LOAD);
        end
    end

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Bench for ex_mem_pipe: a queue-based model of the stage compared every cycle
// on the falling edge, plus directed scenarios with literal expectations.
module tb_ex_mem_pipe;

    logic        clk = 1'b0;
    logic        rst, rdy, flush;
    logic        ex_valid, ex_ready;
    logic [31:0] ex_rd_data;
    logic [4:0]  ex_rd_addr;
    logic        ex_rd_enable;
    logic [1:0]  ex_mem_type;
    logic [2:0]  ex_mem_width;
    logic [31:0] ex_mem_addr;
    logic [31:0] ex_store_data;
    logic        mem_valid, mem_ready;
    logic [31:0] mem_rd_data;
    logic [4:0]  mem_rd_addr;
    logic        mem_rd_enable;
    logic [1:0]  mem_mem_type;
    logic [2:0]  mem_mem_width;
    logic [31:0] mem_mem_addr;
    logic [31:0] mem_store_data;
    logic [4:0]  fwd_query_addr;
    logic        fwd_hit;
    logic [31:0] fwd_data;
    logic        fwd_is_load;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ex_mem_pipe dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_rd_data(ex_rd_data), .ex_rd_addr(ex_rd_addr), .ex_rd_enable(ex_rd_enable),
        .ex_mem_type(ex_mem_type), .ex_mem_width(ex_mem_width),
        .ex_mem_addr(ex_mem_addr), .ex_store_data(ex_store_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_rd_data(mem_rd_data), .mem_rd_addr(mem_rd_addr), .mem_rd_enable(mem_rd_enable),
        .mem_mem_type(mem_mem_type), .mem_mem_width(mem_mem_width),
        .mem_mem_addr(mem_mem_addr), .mem_store_data(mem_store_data),
        .fwd_query_addr(fwd_query_addr), .fwd_hit(fwd_hit),
        .fwd_data(fwd_data), .fwd_is_load(fwd_is_load)
    );

    typedef struct {
        logic [31:0] d;
        logic [4:0]  a;
        logic        en;
        logic [1:0]  t;
        logic [2:0]  w;
        logic [31:0] ma;
        logic [31:0] sd;
    } ent_t;

    ent_t model_q[$];
    bit   model_init  = 0;
    bit   model_clean = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the stage is a FIFO of at most two entries in arrival order.
    always @(posedge clk) begin
        bit   do_push, do_pop;
        ent_t e;
        do_push = ex_valid && !rst && rdy && (model_q.size() < 2);
        do_pop  = (model_q.size() > 0) && mem_ready && rdy;
        e = '{d: ex_rd_data, a: ex_rd_addr, en: ex_rd_enable, t: ex_mem_type,
              w: ex_mem_width, ma: ex_mem_addr, sd: ex_store_data};
        if (rst) begin
            model_q.delete();
            model_init  = 1;
            model_clean = 1;
        end else if (flush) begin
            model_q.delete();
        end else if (rdy) begin
            if (do_pop) void'(model_q.pop_front());
            if (do_push) begin
                model_q.push_back(e);
                model_clean = 0;
            end
        end
    end

    // Compare process on the falling edge.
    always @(negedge clk) begin
        if (model_init) begin
            logic        exp_hit, exp_load;
            logic [31:0] exp_data;
            exp_hit  = 0;
            exp_load = 0;
            exp_data = 0;
            for (int i = model_q.size() - 1; i >= 0; i--) begin
                if (!exp_hit && model_q[i].en && model_q[i].a == fwd_query_addr
                    && fwd_query_addr != 0) begin
                    exp_hit  = 1;
                    exp_data = model_q[i].d;
                    exp_load = (model_q[i].t == 2'b01);
                end
            end
            check("m_ex_ready", ex_ready, !rst && rdy && model_q.size() < 2);
            check("m_mem_valid", mem_valid, model_q.size() > 0);
            check("m_rd_enable", mem_rd_enable, model_q.size() > 0 && model_q[0].en);
            if (model_q.size() > 0) begin
                check("m_rd_data", mem_rd_data, model_q[0].d);
                check("m_rd_addr", mem_rd_addr, model_q[0].a);
                check("m_mem_type", mem_mem_type, model_q[0].t);
                check("m_mem_width", mem_mem_width, model_q[0].w);
                check("m_mem_addr", mem_mem_addr, model_q[0].ma);
                check("m_store_data", mem_store_data, model_q[0].sd);
            end else if (model_clean) begin
                check("m_fields_zero",
                      {mem_rd_data, mem_rd_addr, mem_mem_type, mem_mem_width},
                      64'h0);
                check("m_addr_zero", {mem_mem_addr, mem_store_data}, 64'h0);
            end
            check("m_fwd_hit", fwd_hit, exp_hit);
            check("m_fwd_data", fwd_data, exp_data);
            check("m_fwd_is_load", fwd_is_load, exp_load);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] a, input logic [31:0] d,
                         input logic en, input logic [1:0] t);
        ex_valid      = v;
        ex_rd_addr    = a;
        ex_rd_data    = d;
        ex_rd_enable  = en;
        ex_mem_type   = t;
        ex_mem_width  = a[2:0];
        ex_mem_addr   = {d[15:0], 11'h0, a};
        ex_store_data = d ^ 32'hFFFF_0000;
    endtask

    initial begin
        logic [31:0] held;
        rst = 1; rdy = 1; flush = 0; mem_ready = 0; fwd_query_addr = 0;
        drive(0, 0, 0, 0, 0);
        step(); step();
        check("rst_mem_valid", mem_valid, 0);
        check("rst_mem_rd_data", mem_rd_data, 0);
        rst = 0;
        step();
        check("rst_ex_ready", ex_ready, 1);
        check("rst_fwd_hit", fwd_hit, 0);

        // Streaming with MEM always ready.
        mem_ready = 1;
        for (int i = 1; i <= 4; i++) begin
            drive(1, 5'(i), 32'(i * 'h11), 1, 0);
            step();
            check("stream_valid", mem_valid, 1);
            check("stream_addr", mem_rd_addr, 5'(i));
            check("stream_data", mem_rd_data, 32'(i * 'h11));
            check("stream_ready", ex_ready, 1);
        end
        drive(0, 0, 0, 0, 0);
        step();
        check("stream_drained", mem_valid, 0);

        // Back-pressure fills the skid slot.
        mem_ready = 0;
        drive(1, 5, 32'hAA, 1, 0);
        step();
        check("bp_ready_after_a", ex_ready, 1);
        drive(1, 6, 32'hBB, 1, 0);
        step();
        drive(0, 0, 0, 0, 0);
        check("bp_ready_full", ex_ready, 0);
        check("bp_head_a", mem_rd_data, 32'hAA);
        mem_ready = 1;
        step();
        check("bp_head_b", mem_rd_data, 32'hBB);
        check("bp_ready_back", ex_ready, 1);
        step();
        check("bp_empty", mem_valid, 0);

        // Flush with S full and a simultaneous offer.
        mem_ready = 0;
        drive(1, 8, 32'h80, 1, 0); step();
        drive(1, 9, 32'h90, 1, 0); step();
        flush = 1;
        drive(1, 10, 32'hCC, 1, 0);
        step();
        flush = 0;
        drive(0, 0, 0, 0, 0);
        check("flush_valid", mem_valid, 0);
        check("flush_ready", ex_ready, 1);
        mem_ready = 1;
        step(); step();
        check("flush_no_c", mem_valid, 0);

        // Forwarding: load in H, ALU write to the same register in S.
        mem_ready = 0;
        fwd_query_addr = 7;
        drive(1, 7, 32'h70, 1, 2'b01); step();
        drive(1, 7, 32'h77, 1, 2'b00); step();
        drive(0, 0, 0, 0, 0);
        check("fwd_s_hit", fwd_hit, 1);
        check("fwd_s_data", fwd_data, 32'h77);
        check("fwd_s_not_load", fwd_is_load, 0);
        mem_ready = 1;
        step(); step();
        check("fwd_drained", fwd_hit, 0);
        mem_ready = 0;
        drive(1, 7, 32'h70, 1, 2'b01); step();
        drive(1, 0, 32'h55, 1, 2'b00); step();
        drive(0, 0, 0, 0, 0);
        check("fwd_load_hit", fwd_hit, 1);
        check("fwd_load_flag", fwd_is_load, 1);
        check("fwd_load_data", fwd_data, 32'h70);
        fwd_query_addr = 0;
        #1;
        check("fwd_zero_miss", fwd_hit, 0);
        mem_ready = 1;
        step(); step();

        // Reserved memory type passes through and is not a load.
        mem_ready = 0;
        fwd_query_addr = 3;
        drive(1, 3, 32'h33, 1, 2'b11); step();
        drive(0, 0, 0, 0, 0);
        check("rsv_type", mem_mem_type, 2'b11);
        check("rsv_hit", fwd_hit, 1);
        check("rsv_not_load", fwd_is_load, 0);

        // Freeze: H holds the reserved entry; offers and MEM ready are ignored.
        held = mem_rd_data;
        rdy = 0;
        mem_ready = 1;
        drive(1, 12, 32'hDEAD, 1, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("frz_ready", ex_ready, 0);
            check("frz_valid", mem_valid, 1);
            check("frz_data", mem_rd_data, held);
            check("frz_fwd", fwd_hit, 1);
        end
        rdy = 1;
        drive(0, 0, 0, 0, 0);
        step(); step();

        // Reset with both slots full.
        mem_ready = 0;
        fwd_query_addr = 14;
        drive(1, 13, 32'hD0, 1, 2'b01); step();
        drive(1, 14, 32'hE0, 1, 2'b10); step();
        check("pre_rst_full", ex_ready, 0);
        rst = 1;
        drive(0, 0, 0, 0, 0);
        step();
        check("rst2_valid", mem_valid, 0);
        check("rst2_data", mem_rd_data, 0);
        check("rst2_addr", mem_mem_addr, 0);
        check("rst2_fwd", fwd_hit, 0);
        check("rst2_ready_in_rst", ex_ready, 0);
        rst = 0;
        #1;
        check("rst2_ready", ex_ready, 1);
        step(); step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
